ikbd_acia_rx: RTL and testbench



---
 rtl/ikbd_pkg.sv | 21 ++
 rtl/ikbd_byte_fifo.sv | 49 ++++
 rtl/ikbd_acia_rx.sv | 216 +++++++++++++++++++++
 tb/tb_ikbd_acia_rx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ikbd_pkg.sv
// rtl/ikbd_pkg.sv - shared types and constants for the keyboard serial link
package ikbd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } rx_state_t;

   localparam int OVERSAMPLE       = 16;
   localparam int MID_SAMPLE       = 8;
   localparam int DATA_BITS        = 8;
   localparam int ST_BAUD_CLKS_32M = 256;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/ikbd_byte_fifo.sv
// rtl/ikbd_byte_fifo.sv - small byte FIFO with extra-MSB pointers
module ikbd_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       push,
   input  logic [7:0] din,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       empty,
   output logic       full
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        do_pop;
   logic        do_push;

   assign empty   = (wptr == rptr);
   assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rptr[AW-1:0]];

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         wptr <= '0;
         rptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
            wptr              <= wptr + PTR_ONE;
         end
         if (do_pop) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/ikbd_acia_rx.sv
// rtl/ikbd_acia_rx.sv - 8N1 receiver for the keyboard TxD line with byte FIFO
module ikbd_acia_rx
   import ikbd_pkg::*;
#(
   parameter int CLKS_PER_SAMPLE = ST_BAUD_CLKS_32M,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_busy,
   output logic       framing_err,
   output logic       overrun
);

   localparam int PW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SAMPLE - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
   localparam logic [3:0] S_PRE  = 4'(MID_SAMPLE - 1);
   localparam logic [3:0] S_MID  = 4'(MID_SAMPLE);
   localparam logic [3:0] S_POST = 4'(MID_SAMPLE + 1);
   localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
   // Ticks left in the start bit after its mid-bit check, so data bits align to bit boundaries.
   localparam logic [3:0] S_LEAD_LAST = 4'(OVERSAMPLE - MID_SAMPLE - 2);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

   logic            rx_meta;
   logic            rxs;
   logic            rxs_prev;
   logic [PW-1:0]   presc;
   logic            tick;
   logic            presc_clr;

   rx_state_t       state, state_nxt;
   logic [3:0]      samp, samp_nxt;
   logic [2:0]      bit_idx, bit_idx_nxt;
   logic [7:0]      shreg, shreg_nxt;
   logic            s7, s7_nxt;
   logic            s8, s8_nxt;
   logic            lead, lead_nxt;
   logic            bit_val;

   logic            push;
   logic            fe_nxt;
   logic            ov_nxt;
   logic            fifo_empty;
   logic            fifo_full;
   logic            pop_now;

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         rx_meta  <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         rx_meta  <= rxd;
         rxs      <= rx_meta;
         rxs_prev <= rxs;
      end
   end

   assign tick = (presc == PRESC_LAST);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         presc <= '0;
      end else if (presc_clr || tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PRESC_ONE;
      end
   end

   assign bit_val = majority3(s7, s8, rxs);
   assign pop_now = rx_ready & ~fifo_empty;
   assign rx_valid = ~fifo_empty;
   assign rx_busy  = (state != IDLE);

   always_comb begin
      state_nxt   = state;
      samp_nxt    = samp;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      s7_nxt      = s7;
      s8_nxt      = s8;
      lead_nxt    = lead;
      presc_clr   = 1'b0;
      push        = 1'b0;
      fe_nxt      = 1'b0;
      ov_nxt      = 1'b0;

      case (state)
         IDLE: begin
            if (rxs_prev && !rxs) begin
               state_nxt = START;
               samp_nxt  = '0;
               presc_clr = 1'b1;
            end
         end

         START: begin
            if (tick) begin
               samp_nxt = samp + 4'd1;
               if (samp == S_MID) begin
                  if (!rxs) begin
                     state_nxt   = DATA;
                     bit_idx_nxt = '0;
                     samp_nxt    = '0;
                     lead_nxt    = 1'b1;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end

         DATA: begin
            if (tick) begin
               if (lead) begin
                  if (samp == S_LEAD_LAST) begin
                     lead_nxt = 1'b0;
                     samp_nxt = '0;
                  end else begin
                     samp_nxt = samp + 4'd1;
                  end
               end else begin
                  samp_nxt = samp + 4'd1;
                  if (samp == S_PRE)  s7_nxt = rxs;
                  if (samp == S_MID)  s8_nxt = rxs;
                  if (samp == S_POST) shreg_nxt = {bit_val, shreg[7:1]};
                  if (samp == S_LAST) begin
                     if (bit_idx == BIT_LAST) begin
                        state_nxt = STOP;
                     end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                     end
                  end
               end
            end
         end

         STOP: begin
            if (tick) begin
               samp_nxt = samp + 4'd1;
               if (samp == S_PRE) s7_nxt = rxs;
               if (samp == S_MID) s8_nxt = rxs;
               // Decide mid stop bit so a back-to-back start edge is still seen from IDLE.
               if (samp == S_POST) begin
                  if (bit_val) begin
                     state_nxt = IDLE;
                     if (!fifo_full || pop_now) begin
                        push = 1'b1;
                     end else begin
                        ov_nxt = 1'b1;
                     end
                  end else begin
                     state_nxt = BREAK;
                     fe_nxt    = 1'b1;
                  end
               end
            end
         end

         BREAK: begin
            if (rxs) begin
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         state       <= IDLE;
         samp        <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         s7          <= 1'b0;
         s8          <= 1'b0;
         lead        <= 1'b0;
         framing_err <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state       <= state_nxt;
         samp        <= samp_nxt;
         bit_idx     <= bit_idx_nxt;
         shreg       <= shreg_nxt;
         s7          <= s7_nxt;
         s8          <= s8_nxt;
         lead        <= lead_nxt;
         framing_err <= fe_nxt;
         overrun     <= ov_nxt;
      end
   end

   ikbd_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .res_n (res_n),
      .push  (push),
      .din   (shreg),
      .pop   (rx_ready),
      .dout  (rx_data),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_ikbd_acia_rx.sv
// tb/tb_ikbd_acia_rx.sv - self-checking bench for the keyboard serial receiver
module tb_ikbd_acia_rx;

   localparam int CPS   = 8;
   localparam int DEPTH = 4;
   localparam int P     = 16 * CPS;

   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       rxd = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       framing_err;
   logic       overrun;

   int tests = 0;
   int failed = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   int fe_cnt = 0;
   int ov_cnt = 0;
   int busy_cnt = 0;
   int valid_cnt = 0;

   ikbd_acia_rx #(
      .CLKS_PER_SAMPLE (CPS),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk         (clk),
      .res_n       (res_n),
      .rxd         (rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_busy     (rx_busy),
      .framing_err (framing_err),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (framing_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_busy) busy_cnt++;
      if (rx_valid) valid_cnt++;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Serial frame at 'per' clocks per bit; glitch_bit >= 0 inverts one sample period mid-bit.
   task automatic send_byte(input logic [7:0] b, input int per, input logic stop_bit,
                            input int glitch_bit);
      rxd = 1'b0;
      wait_clks(per);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         if (i == glitch_bit) begin
            wait_clks(per / 2);
            rxd = ~b[i];
            wait_clks(CPS);
            rxd = b[i];
            wait_clks(per - per / 2 - CPS);
         end else begin
            wait_clks(per);
         end
      end
      rxd = stop_bit;
      wait_clks(per);
      rxd = 1'b1;
   endtask

   task automatic check_rx(input string tag, input int gb, input int fb, input int ob,
                           input int exp_fe, input int exp_ov);
      check({tag, "_count"}, got_q.size() - gb, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (gb + i < got_q.size())
            check($sformatf("%s_byte%0d", tag, i), got_q[gb + i], exp_q[i]);
      end
      check({tag, "_framing"}, fe_cnt - fb, exp_fe);
      check({tag, "_overrun"}, ov_cnt - ob, exp_ov);
      exp_q.delete();
   endtask

   initial begin
      int gb, fb, ob, bb, vb;
      int occ, exp_ov, per, gap;
      logic rdy;
      logic [7:0] b;
      logic [7:0] stall_bytes [4];
      stall_bytes[0] = 8'h1C;
      stall_bytes[1] = 8'h9C;
      stall_bytes[2] = 8'h3A;
      stall_bytes[3] = 8'hBA;

      // Reset state
      res_n = 1'b0;
      wait_clks(5);
      check("reset_valid", rx_valid, 1'b0);
      check("reset_busy", rx_busy, 1'b0);
      check("reset_data", rx_data, 8'h00);
      check("reset_framing", framing_err, 1'b0);
      check("reset_overrun", overrun, 1'b0);
      res_n = 1'b1;
      wait_clks(20);

      // Single byte with consumer ready
      rx_ready = 1'b1;
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt; bb = busy_cnt; vb = valid_cnt;
      send_byte(8'hF1, P, 1'b1, -1);
      exp_q.push_back(8'hF1);
      wait_clks(2 * P);
      check("single_valid_cycles", valid_cnt - vb, 1);
      check("single_busy_window", (busy_cnt - bb >= 9 * P) && (busy_cnt - bb <= 10 * P), 1'b1);
      check_rx("single", gb, fb, ob, 0, 0);

      // Back-to-back with stalled consumer, fifth byte overruns
      rx_ready = 1'b0;
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt;
      for (int i = 0; i < 4; i++) begin
         send_byte(stall_bytes[i], P, 1'b1, -1);
         exp_q.push_back(stall_bytes[i]);
      end
      send_byte(8'h55, P, 1'b1, -1);
      wait_clks(P);
      check("stall_valid", rx_valid, 1'b1);
      check("stall_head", rx_data, 8'h1C);
      check("stall_overrun_seen", ov_cnt - ob, 1);
      wait_clks(50);
      check("stall_head_stable", rx_data, 8'h1C);
      rx_ready = 1'b1;
      wait_clks(20);
      check_rx("stall", gb, fb, ob, 0, 1);
      check("stall_drained", rx_valid, 1'b0);

      // Framing error then good byte
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt;
      send_byte(8'hA5, P, 1'b0, -1);
      wait_clks(2 * P);
      send_byte(8'h42, P, 1'b1, -1);
      exp_q.push_back(8'h42);
      wait_clks(2 * P);
      check_rx("framing", gb, fb, ob, 1, 0);

      // Short glitch on idle line is a false start
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt;
      rxd = 1'b0;
      wait_clks(3 * CPS);
      rxd = 1'b1;
      wait_clks(2 * P);
      check("glitch_idle", rx_busy, 1'b0);
      check_rx("glitch", gb, fb, ob, 0, 0);

      // Break: line low for five byte times
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt;
      rxd = 1'b0;
      wait_clks(50 * P);
      check("break_busy", rx_busy, 1'b1);
      rxd = 1'b1;
      wait_clks(2 * P);
      check("break_idle", rx_busy, 1'b0);
      check_rx("break", gb, fb, ob, 1, 0);

      // Baud tolerance and single-sample glitch in bit 3
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt;
      send_byte(8'h6E, P - 4, 1'b1, -1);
      exp_q.push_back(8'h6E);
      wait_clks(2 * P);
      send_byte(8'h6E, P + 4, 1'b1, -1);
      exp_q.push_back(8'h6E);
      wait_clks(2 * P);
      send_byte(8'h6E, P, 1'b1, 3);
      exp_q.push_back(8'h6E);
      wait_clks(2 * P);
      check_rx("tolerance", gb, fb, ob, 0, 0);

      // Reset during bit 4 of 0x81 with a byte already queued
      rx_ready = 1'b0;
      send_byte(8'h3C, P, 1'b1, -1);
      wait_clks(P);
      check("prereset_head", rx_data, 8'h3C);
      fork
         send_byte(8'h81, P, 1'b1, -1);
         begin
            wait_clks(5 * P + P / 2);
            res_n = 1'b0;
            #1;
            check("midreset_valid", rx_valid, 1'b0);
            check("midreset_data", rx_data, 8'h00);
            check("midreset_busy", rx_busy, 1'b0);
            check("midreset_framing", framing_err, 1'b0);
            check("midreset_overrun", overrun, 1'b0);
            wait_clks(3 * P);
            res_n = 1'b1;
         end
      join
      wait_clks(2 * P);
      check("postreset_empty", rx_valid, 1'b0);
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt;
      rx_ready = 1'b1;
      send_byte(8'h7F, P, 1'b1, -1);
      exp_q.push_back(8'h7F);
      wait_clks(2 * P);
      check_rx("reset", gb, fb, ob, 0, 0);

      // Random bytes, rates, gaps and consumer stalls against an occupancy model
      gb = got_q.size(); fb = fe_cnt; ob = ov_cnt;
      occ = 0;
      exp_ov = 0;
      for (int i = 0; i < 12; i++) begin
         b   = 8'($urandom);
         rdy = ($urandom_range(0, 9) < 4);
         per = $urandom_range(P - 2, P + 2);
         gap = $urandom_range(0, 2);
         rx_ready = rdy;
         send_byte(b, per, 1'b1, -1);
         if (rdy) begin
            occ = 0;
            exp_q.push_back(b);
         end else if (occ == DEPTH) begin
            exp_ov++;
         end else begin
            occ++;
            exp_q.push_back(b);
         end
         if (gap > 0) wait_clks(gap * P);
      end
      rx_ready = 1'b1;
      wait_clks(2 * P);
      check_rx("random", gb, fb, ob, 0, exp_ov);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
